// File: rtl/motoro_3ph_if.sv
// Control/status bundle between the motoro top level and the three-phase
// commutation generator: run request, direction, speed word, gate drives and status.
interface motoro_3ph_if #(
    parameter int FREQ_W = 10
);
    logic              m3start;
    logic              m3dir;
    logic [FREQ_W-1:0] m3freq;
    logic              aH;
    logic              aL;
    logic              bH;
    logic              bL;
    logic              cH;
    logic              cL;
    logic              m3running;
    logic [2:0]        m3step;
    logic [FREQ_W-1:0] m3curFreq;

    modport master (
        output m3start, m3dir, m3freq,
        input  aH, aL, bH, bL, cH, cL, m3running, m3step, m3curFreq
    );

    modport slave (
        input  m3start, m3dir, m3freq,
        output aH, aL, bH, bL, cH, cL, m3running, m3step, m3curFreq
    );
endinterface

// File: rtl/motoro_3ph_gen.sv
// Six-step three-phase commutation generator: phase-accumulator stepping,
// soft start/stop frequency slew, stop-before-reverse and per-driver dead time.
module motoro_3ph_gen #(
    parameter int FREQ_W      = 10,
    parameter int ACC_W       = 16,
    parameter int TICK_DIV    = 500,
    parameter int RAMP_TICKS  = 100,
    parameter int RAMP_STEP   = 1,
    parameter int DEAD_CYCLES = 50
) (
    input  logic             clk50mhz,
    input  logic             nReset,
    motoro_3ph_if.slave      bus
);

    localparam int PRE_W  = (TICK_DIV > 1)    ? $clog2(TICK_DIV)      : 1;
    localparam int RMP_W  = (RAMP_TICKS > 1)  ? $clog2(RAMP_TICKS)    : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES+1) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [RMP_W-1:0]  RMP_LAST  = RMP_W'(RAMP_TICKS - 1);
    localparam logic [DEAD_W-1:0] DEAD_SAT  = DEAD_W'(DEAD_CYCLES);
    localparam logic [FREQ_W-1:0] FSTEP     = FREQ_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNxt;
    logic                r_dirLatched;
    logic [PRE_W-1:0]    r_presc;
    logic [RMP_W-1:0]    r_rampCnt;
    logic [ACC_W-1:0]    r_acc;
    logic [FREQ_W-1:0]   r_curFreq;
    logic [2:0]          r_step;
    logic [5:0]          r_drv;
    logic [DEAD_W-1:0]   r_offCnt [6];

    logic                w_tick;
    logic                w_active;
    logic                w_drvEn;
    logic [ACC_W:0]      w_sum;
    logic [FREQ_W-1:0]   w_goal;
    logic [5:0]          w_req;
    logic [5:0]          w_cmp;

    // Move cur one slew step toward goal, landing exactly on goal rather than past it.
    function automatic logic [FREQ_W-1:0] f_slew(input logic [FREQ_W-1:0] cur,
                                                  input logic [FREQ_W-1:0] goal);
        logic [FREQ_W-1:0] diff;
        f_slew = cur;
        if (cur < goal) begin
            diff   = goal - cur;
            f_slew = (diff > FSTEP) ? cur + FSTEP : goal;
        end else if (cur > goal) begin
            diff   = cur - goal;
            f_slew = (diff > FSTEP) ? cur - FSTEP : goal;
        end
    endfunction

    function automatic logic [2:0] f_nextStep(input logic [2:0] s, input logic rev);
        if (rev) f_nextStep = (s == 3'd0) ? 3'd5 : s - 3'd1;
        else     f_nextStep = (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    // Bit order {aH, aL, bH, bL, cH, cL}; one high side and one low side per step.
    function automatic logic [5:0] f_stepTable(input logic [2:0] s);
        case (s)
            3'd0:    f_stepTable = 6'b100100;
            3'd1:    f_stepTable = 6'b100001;
            3'd2:    f_stepTable = 6'b001001;
            3'd3:    f_stepTable = 6'b011000;
            3'd4:    f_stepTable = 6'b010010;
            3'd5:    f_stepTable = 6'b000110;
            default: f_stepTable = 6'b000000;
        endcase
    endfunction

    assign w_tick   = (r_presc == PRE_LAST);
    assign w_active = (r_state != IDLE);
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - FREQ_W){1'b0}}, r_curFreq};
    assign w_goal   = (r_state == RUN) ? bus.m3freq : '0;
    assign w_req    = f_stepTable(r_step);
    assign w_cmp    = {r_drv[4], r_drv[5], r_drv[2], r_drv[3], r_drv[0], r_drv[1]};
    // Gating on the next state too lets drivers drop on the same edge m3running falls.
    assign w_drvEn  = w_active && (w_stateNxt != IDLE);

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m3start && (bus.m3freq != '0)) w_stateNxt = RUN;
            end
            RUN: begin
                if (!bus.m3start || (bus.m3freq == '0) || (bus.m3dir != r_dirLatched))
                    w_stateNxt = STOPPING;
            end
            STOPPING: begin
                if (r_curFreq == '0) w_stateNxt = IDLE;
            end
            default: w_stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_dirLatched <= 1'b0;
        end else begin
            r_state <= w_stateNxt;
            if ((r_state == IDLE) && (w_stateNxt == RUN))
                r_dirLatched <= bus.m3dir;
        end
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_acc     <= '0;
            r_curFreq <= '0;
            r_rampCnt <= '0;
            r_step    <= 3'd0;
        end else if (!w_active) begin
            r_acc     <= '0;
            r_curFreq <= '0;
            r_rampCnt <= '0;
        end else if (w_tick) begin
            r_acc <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W])
                r_step <= f_nextStep(r_step, r_dirLatched);
            if (r_rampCnt == RMP_LAST) begin
                r_rampCnt <= '0;
                r_curFreq <= f_slew(r_curFreq, w_goal);
            end else begin
                r_rampCnt <= r_rampCnt + 1'b1;
            end
        end
    end

    // A driver may only turn on once its complement has been off for DEAD_CYCLES clocks.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_drv <= '0;
            for (int i = 0; i < 6; i++) r_offCnt[i] <= DEAD_SAT;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_cmp[i])
                    r_offCnt[i] <= '0;
                else if (r_offCnt[i] != DEAD_SAT)
                    r_offCnt[i] <= r_offCnt[i] + 1'b1;
                r_drv[i] <= w_req[i] && w_drvEn && (r_offCnt[i] == DEAD_SAT);
            end
        end
    end

    assign bus.aH        = r_drv[5];
    assign bus.aL        = r_drv[4];
    assign bus.bH        = r_drv[3];
    assign bus.bL        = r_drv[2];
    assign bus.cH        = r_drv[1];
    assign bus.cL        = r_drv[0];
    assign bus.m3running = w_active;
    assign bus.m3step    = r_step;
    assign bus.m3curFreq = r_curFreq;

endmodule
